// File: rtl/pll_freq_checker_pkg.sv
// Shared types and helpers for the PLL frequency checker.
package pll_freq_checker_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    MEASURE   = 2'd2,
    COMPARE   = 2'd3
  } state_e;

  localparam int LOCK_CNT_W = 8;

  // Down-counters load N-1, so clog2(N) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_freq_checker_toggle_sync_edge.sv
// Multi-flop synchroniser followed by a both-edge detector (one-cycle pulse).
module toggle_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/pll_freq_checker.sv
// Gated per-channel edge counter with min/max verdict, active only while locked.
// Define PLL_FREQ_CHECKER_STICKY_EN to make fail bits sticky until reset.
//
// state     | meaning
// WAIT_LOCK | idle until synchronised locked is high
// SETTLE    | lock must hold for SETTLE_CYCLES before measuring
// MEASURE   | count toggle edges for GATE_CYCLES cycles
// COMPARE   | publish counts and verdict, restart the window
module pll_freq_checker
  import pll_freq_checker_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 256,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      locked,
  input  logic [CHANNELS-1:0]       tog_in,
  input  logic [CHANNELS*CNT_W-1:0] exp_min,
  input  logic [CHANNELS*CNT_W-1:0] exp_max,
  output logic [CHANNELS*CNT_W-1:0] meas_cnt,
  output logic                      meas_valid,
  output logic [CHANNELS-1:0]       pass,
  output logic [CHANNELS-1:0]       fail,
  output logic [LOCK_CNT_W-1:0]     lock_loss_cnt,
  output logic                      busy
);

  localparam int GW = cnt_width(GATE_CYCLES);
  localparam int SW = cnt_width(SETTLE_CYCLES);

  state_e                           state_q, state_d;
  logic [GW-1:0]                    gate_q, gate_d;
  logic [SW-1:0]                    settle_q, settle_d;
  logic [CHANNELS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0]   meas_q, meas_d;
  logic [CHANNELS-1:0]              pass_q, pass_d, fail_q, fail_d;
  logic                             valid_q, valid_d;
  logic [LOCK_CNT_W-1:0]            loss_q, loss_d;
  logic [CHANNELS-1:0]              tog_edge, in_bounds, tog_sync_unused;
  logic                             lock_s, lock_edge_unused;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tog (
      .clk    (clk),
      .rst    (rst),
      .d_i    (tog_in[i]),
      .sync_o (tog_sync_unused[i]),
      .edge_o (tog_edge[i])
    );
  end

  toggle_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lock (
    .clk    (clk),
    .rst    (rst),
    .d_i    (locked),
    .sync_o (lock_s),
    .edge_o (lock_edge_unused)
  );

  // An inverted bound pair can never be satisfied, so that channel always fails.
  always_comb begin
    in_bounds = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_bounds[i] = (exp_min[i*CNT_W +: CNT_W] <= cnt_q[i]) &&
                     (cnt_q[i] <= exp_max[i*CNT_W +: CNT_W]);
    end
  end

  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    meas_d   = meas_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    valid_d  = 1'b0;
    loss_d   = loss_q;

    if (state_q != WAIT_LOCK && !lock_s) begin
      // Lock dropped: discard the window in progress, outputs hold.
      state_d = WAIT_LOCK;
      if (loss_q != '1) loss_d = loss_q + 1'b1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            settle_d = SW'(SETTLE_CYCLES - 1);
            state_d  = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_q == '0) begin
            cnt_d   = '0;
            gate_d  = GW'(GATE_CYCLES - 1);
            state_d = MEASURE;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        MEASURE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (tog_edge[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
          end
          if (gate_q == '0) state_d = COMPARE;
          else              gate_d  = gate_q - 1'b1;
        end
        COMPARE: begin
          meas_d  = cnt_q;
          valid_d = 1'b1;
`ifdef PLL_FREQ_CHECKER_STICKY_EN
          fail_d  = fail_q | ~in_bounds;
          pass_d  = in_bounds & ~fail_d;
`else
          fail_d  = ~in_bounds;
          pass_d  = in_bounds;
`endif
          cnt_d   = '0;
          gate_d  = GW'(GATE_CYCLES - 1);
          state_d = MEASURE;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      gate_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      meas_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      valid_q  <= 1'b0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      gate_q   <= gate_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      valid_q  <= valid_d;
      loss_q   <= loss_d;
    end
  end

  assign meas_cnt      = meas_q;
  assign meas_valid    = valid_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = loss_q;
  assign busy          = (state_q == SETTLE) || (state_q == MEASURE);

endmodule

// File: tb/tb_pll_freq_checker.sv
// Directed bench: expected window results queued at stimulus time, checked on meas_valid.
module tb_pll_freq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked = 1'b0;
  logic        tog0 = 1'b0, tog1 = 1'b0, tog_s = 1'b0;
  int          per0 = 8, per1 = 2;
  logic [31:0] exp_min = {16'd500, 16'd120};
  logic [31:0] exp_max = {16'd520, 16'd136};
  logic [3:0]  sat_min = 4'd0, sat_max = 4'd14;
  wire  [1:0]  tog_in = {tog1, tog0};
  wire  [0:0]  tog_sat = tog_s;

  logic [31:0] meas_cnt;
  logic        meas_valid, busy;
  logic [1:0]  pass, fail;
  logic [7:0]  lock_loss_cnt;

  logic [3:0]  sat_cnt;
  logic        sat_valid, sat_busy_unused;
  logic [0:0]  sat_pass, sat_fail;
  logic [7:0]  sat_loss_unused;

  int tests = 0, fails = 0, vcount = 0, sat_seen = 0, cyc = 0, v_before = 0;

  typedef struct {
    bit         skip;
    int         c0;
    int         c1;
    logic [1:0] p;
    logic [1:0] f;
  } exp_t;
  exp_t sb[$];
  exp_t e;

`ifdef PLL_FREQ_CHECKER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  pll_freq_checker #(
    .CHANNELS(2), .CNT_W(16), .GATE_CYCLES(1024), .SETTLE_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .tog_in(tog_in),
    .exp_min(exp_min), .exp_max(exp_max), .meas_cnt(meas_cnt),
    .meas_valid(meas_valid), .pass(pass), .fail(fail),
    .lock_loss_cnt(lock_loss_cnt), .busy(busy)
  );

  pll_freq_checker #(
    .CHANNELS(1), .CNT_W(4), .GATE_CYCLES(32), .SETTLE_CYCLES(4), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .locked(locked), .tog_in(tog_sat),
    .exp_min(sat_min), .exp_max(sat_max), .meas_cnt(sat_cnt),
    .meas_valid(sat_valid), .pass(sat_pass), .fail(sat_fail),
    .lock_loss_cnt(sat_loss_unused), .busy(sat_busy_unused)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (per0) @(posedge clk);
    #1 tog0 = ~tog0;
  end
  initial forever begin
    repeat (per1) @(posedge clk);
    #1 tog1 = ~tog1;
  end
  initial forever begin
    @(posedge clk);
    #1 tog_s = ~tog_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input bit skip, input int c0, input int c1,
                      input logic [1:0] p, input logic [1:0] f);
    exp_t x;
    x.skip = skip; x.c0 = c0; x.c1 = c1; x.p = p; x.f = f;
    sb.push_back(x);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (meas_valid !== 1'b1 && n < bound);
    check("valid_within_bound", 32'(n < bound), 32'd1);
  endtask

  // Scoreboard side: every result pulse must match the oldest queued window.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      vcount++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!e.skip) begin
          check("cnt0", 32'(meas_cnt[15:0]), e.c0);
          check("cnt1", 32'(meas_cnt[31:16]), e.c1);
          check("pass", 32'(pass), 32'(e.p));
          check("fail", 32'(fail), 32'(e.f));
        end
      end
    end
    if (sat_valid === 1'b1) begin
      sat_seen++;
      check("sat_cnt", 32'(sat_cnt), 32'd15);
      check("sat_fail", 32'(sat_fail), 32'd1);
      check("sat_pass", 32'(sat_pass), 32'd0);
    end
  end

  initial begin
    // Reset state, then released with lock low: nothing may start.
    repeat (3) @(negedge clk);
    check("rst_cnt", meas_cnt, 32'd0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_loss", 32'(lock_loss_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("unlocked_busy", 32'(busy), 32'd0);

    // Window 1: both channels in bounds; lock-to-valid = 2 sync + 1 + 16 + 1024 + 1.
    push(0, 128, 512, 2'b11, 2'b00);
    locked = 1'b1;
    repeat (5) @(negedge clk);
    check("settle_busy", 32'(busy), 32'd1);
    wait_valid(1200, cyc);
    check("first_latency", cyc + 5, 32'd1044);

    // Channel 1 slowed to 1/4: transitional window skipped, next one out of bounds.
    per1 = 4;
    push(1, 0, 0, 2'b00, 2'b00);
    wait_valid(1100, cyc);
    push(0, 128, 256, 2'b01, 2'b10);
    wait_valid(1100, cyc);

    // Lock drop ~500 cycles into the next window: discarded, results held.
    repeat (500) @(negedge clk);
    v_before = vcount;
    locked = 1'b0;
    repeat (600) @(negedge clk);
    check("drop_no_valid", vcount, v_before);
    check("drop_loss", 32'(lock_loss_cnt), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_hold_cnt1", 32'(meas_cnt[31:16]), 32'd256);
    check("drop_hold_cnt0", 32'(meas_cnt[15:0]), 32'd128);
    check("drop_hold_pass", 32'(pass), 32'd1);
    check("drop_hold_fail", 32'(fail), 32'd2);

    // Relock: settle repeats, so latency matches the first window.
    push(0, 128, 256, 2'b01, 2'b10);
    locked = 1'b1;
    wait_valid(1200, cyc);
    check("relock_latency", cyc, 32'd1044);
    check("relock_loss", 32'(lock_loss_cnt), 32'd1);

    // Channel 1 back in bounds; sticky build keeps its earlier failure.
    per1 = 2;
    push(1, 0, 0, 2'b00, 2'b00);
    wait_valid(1100, cyc);
    push(0, 128, 512, STICKY ? 2'b01 : 2'b11, STICKY ? 2'b10 : 2'b00);
    wait_valid(1100, cyc);

    // Reset mid-window: everything clears on the next edge.
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cnt", meas_cnt, 32'd0);
    check("mid_rst_valid", 32'(meas_valid), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    check("mid_rst_fail", 32'(fail), 32'd0);
    check("mid_rst_loss", 32'(lock_loss_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("post_rst_settle", 32'(busy), 32'd1);

    check("sat_windows_seen", 32'(sat_seen > 0), 32'd1);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
